// File: rtl/serdes_pkg.sv
// Shared sizing helpers and state type for the serializer front-end arbiter.
package serdes_pkg;

  typedef enum logic {EMPTY = 1'b0, LOADED = 1'b1} state_t;

  function automatic int num_seg(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // Channel-id width; a single channel still needs one bit of index.
  function automatic int ch_width(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int cnt_width(input int segs);
    return (segs <= 1) ? 1 : $clog2(segs);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by ptr, pick lowest, rotate back.
module rr_arbiter
  import serdes_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int CW = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     ptr,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [CW-1:0]     idx
);

  logic [2*NUM_CH-1:0] dbl_req;
  logic [2*NUM_CH-1:0] dbl_gnt;
  logic [NUM_CH-1:0]   rot_req;
  logic [NUM_CH-1:0]   rot_gnt;
  logic [CW-1:0]       sel;
  logic [CW:0]         sum;
  logic                found;

  always_comb begin
    dbl_req = {req, req} >> ptr;
    rot_req = dbl_req[NUM_CH-1:0];
    sel     = '0;
    found   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rot_req[i]) begin
        sel   = CW'(i);
        found = 1'b1;
      end
    end
    rot_gnt = (enable && found) ? (NUM_CH'(1) << sel) : '0;
    dbl_gnt = {rot_gnt, rot_gnt} << ptr;
    grant   = dbl_gnt[2*NUM_CH-1:NUM_CH];
    sum     = {1'b0, sel} + {1'b0, ptr};
    if (sum >= (CW+1)'(NUM_CH)) sum = sum - (CW+1)'(NUM_CH);
    idx = sum[CW-1:0];
  end

endmodule

// File: rtl/ser_arbiter.sv
// Round-robin front-end that shares one wide-to-narrow serializer among NUM_CH
// requesters and tags every narrow beat with its source channel.
module ser_arbiter
  import serdes_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int IN_W      = 512,
  parameter int OUT_W     = 32,
  parameter int TAG_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH*IN_W-1:0]     req_data,
  output logic [NUM_CH-1:0]          req_ready,
  output logic                       ser_data_ready,
  output logic [IN_W-1:0]            ser_data_in,
  input  logic                       ser_read_data,
  input  logic                       ser_write_data,
  output logic [$clog2(NUM_CH)-1:0]  out_ch,
  output logic                       out_last,
  output logic                       err_orphan
);

  localparam int CH_W    = ch_width(NUM_CH);
  localparam int NUM_SEG = num_seg(IN_W, OUT_W);
  localparam int CNT_W   = cnt_width(NUM_SEG);
  localparam int PTR_W   = $clog2(TAG_DEPTH);

  state_t           state;
  logic [CH_W-1:0]  grant_ch;
  logic [CH_W-1:0]  rr_ptr;
  logic [CH_W-1:0]  tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_next;
  logic [CNT_W-1:0] beat_cnt;

  logic            xfer, push, pop, tag_full, tag_full_next, tag_empty;
  logic            load_en, load, beat_last;
  logic [CH_W-1:0] grant_idx;

  assign tag_full       = (count == (PTR_W+1)'(TAG_DEPTH));
  assign tag_empty      = (count == '0);
  assign ser_data_ready = (state == LOADED) && !tag_full;
  assign xfer           = ser_data_ready && ser_read_data;
  assign push           = xfer;
  assign beat_last      = (beat_cnt == CNT_W'(NUM_SEG - 1));
  assign pop            = ser_write_data && !tag_empty && beat_last;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + (PTR_W+1)'(1);
    else if (pop && !push) count_next = count - (PTR_W+1)'(1);
  end
  assign tag_full_next = (count_next == (PTR_W+1)'(TAG_DEPTH));

  // Reloading on the xfer edge itself is what keeps back-to-back words bubble-free.
  assign load_en = ((state == EMPTY) || xfer) && !tag_full_next;
  assign load    = load_en && (|req_valid);

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .enable (load_en),
    .grant  (req_ready),
    .idx    (grant_idx)
  );

  assign out_ch   = tag_empty ? '0 : tag_mem[rd_ptr];
  assign out_last = beat_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= EMPTY;
      ser_data_in <= '0;
      grant_ch    <= '0;
      rr_ptr      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      beat_cnt    <= '0;
      err_orphan  <= 1'b0;
      for (int i = 0; i < TAG_DEPTH; i++) tag_mem[i] <= '0;
    end else begin
      if (load) begin
        state       <= LOADED;
        ser_data_in <= req_data[grant_idx*IN_W +: IN_W];
        grant_ch    <= grant_idx;
        rr_ptr      <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
      end else if (xfer) begin
        state <= EMPTY;
      end
      // Push carries the tag of the word leaving now, not one loaded this cycle.
      if (push) begin
        tag_mem[wr_ptr] <= grant_ch;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (ser_write_data) begin
        if (tag_empty) begin
          err_orphan <= 1'b1;
        end else if (beat_last) begin
          beat_cnt <= '0;
          rd_ptr   <= rd_ptr + PTR_W'(1);
        end else begin
          beat_cnt <= beat_cnt + CNT_W'(1);
        end
      end
      count <= count_next;
    end
  end

endmodule

// File: tb/tb_ser_arbiter.sv
// Directed bench for ser_arbiter; the bench plays the serializer side of the handshake.
module tb_ser_arbiter;

  localparam int NUM_CH = 4;
  localparam int IN_W   = 512;
  localparam int OUT_W  = 32;
  localparam int NSEG   = IN_W / OUT_W;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_CH-1:0]      req_valid;
  logic [NUM_CH*IN_W-1:0] req_data;
  logic [NUM_CH-1:0]      req_ready;
  logic                   ser_data_ready;
  logic [IN_W-1:0]        ser_data_in;
  logic                   ser_read_data;
  logic                   ser_write_data;
  logic [1:0]             out_ch;
  logic                   out_last;
  logic                   err_orphan;

  int checks   = 0;
  int failures = 0;

  ser_arbiter #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .TAG_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ser_data_ready(ser_data_ready), .ser_data_in(ser_data_in),
    .ser_read_data(ser_read_data), .ser_write_data(ser_write_data),
    .out_ch(out_ch), .out_last(out_last), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rv;
    logic       rd;
    logic       wd;
    logic [3:0] rr;
    logic       dr;
    logic [1:0] ch;
    logic       last;
    logic       err;
    int         din;
  } vec_t;

  vec_t tbl [8];

  function automatic logic [IN_W-1:0] wordf(input logic [7:0] tag);
    logic [IN_W-1:0] w;
    for (int k = 0; k < NSEG; k++) w[k*OUT_W +: OUT_W] = {tag, 8'h00, 16'(k)};
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [IN_W-1:0] exp);
    checks++;
    if (ser_data_in !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, ser_data_in[63:0], exp[63:0]);
    end
  endtask

  // Drive one cycle, check the combinational/registered outputs, then clock it.
  task automatic step(input string nm, input logic [3:0] rv, input logic rd, input logic wd,
                      input logic [3:0] err_rr, input logic edr, input logic [1:0] ech,
                      input logic elast, input logic eerr);
    req_valid = rv; ser_read_data = rd; ser_write_data = wd;
    #1;
    chk({nm, ".req_ready"}, 32'(req_ready), 32'(err_rr));
    chk({nm, ".data_ready"}, 32'(ser_data_ready), 32'(edr));
    chk({nm, ".out_ch"}, 32'(out_ch), 32'(ech));
    chk({nm, ".out_last"}, 32'(out_last), 32'(elast));
    chk({nm, ".err_orphan"}, 32'(err_orphan), 32'(eerr));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req_valid = '0; ser_read_data = 1'b0; ser_write_data = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    req_valid = '0; ser_read_data = 1'b0; ser_write_data = 1'b0; reset = 1'b1;
    for (int c = 0; c < NUM_CH; c++) req_data[c*IN_W +: IN_W] = wordf(8'(c));

    // All channels valid: strict rotation, zero-bubble reloads, fill to TAG_DEPTH.
    tbl[0] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, -1};
    tbl[1] = '{4'b1111, 1'b0, 1'b0, 4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, -1};
    tbl[2] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0,  0};
    tbl[3] = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0, 1'b0, 1'b0,  0};
    tbl[4] = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd0, 1'b0, 1'b0,  1};
    tbl[5] = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd0, 1'b0, 1'b0,  2};
    tbl[6] = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0,  3};
    tbl[7] = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0,  3};

    do_reset();
    chkw("reset.data_in", '0);
    for (int i = 0; i < 8; i++) begin
      req_valid = tbl[i].rv;
      #1;
      if (tbl[i].din < 0) chkw($sformatf("tbl%0d.data_in", i), '0);
      else chkw($sformatf("tbl%0d.data_in", i), wordf(8'(tbl[i].din)));
      step($sformatf("tbl%0d", i), tbl[i].rv, tbl[i].rd, tbl[i].wd, tbl[i].rr,
           tbl[i].dr, tbl[i].ch, tbl[i].last, tbl[i].err);
    end

    // Tag FIFO full: stalled until the first word's last beat pops, then ch0 reloads.
    for (int k = 0; k < NSEG; k++)
      step($sformatf("bp%0d", k), 4'b1111, 1'b0, 1'b1, (k == NSEG-1) ? 4'b0001 : 4'b0000,
           1'b0, 2'd0, k == NSEG-1, 1'b0);
    chkw("bp.reload", wordf(8'd0));
    for (int w = 1; w < 4; w++)
      for (int k = 0; k < NSEG; k++)
        step($sformatf("drain%0d_%0d", w, k), 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1,
             2'(w), k == NSEG-1, 1'b0);
    step("xfer_last", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < NSEG; k++)
      step($sformatf("ch0w_%0d", k), 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0,
           k == NSEG-1, 1'b0);
    chkw("hold_after_xfer", wordf(8'd0));

    // Orphan beats: sticky error, beat counter does not move.
    step("orph0", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    step("orph1", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
    step("orph2", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b1);
    do_reset();
    step("orph_clr", 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);

    // Single active channel granted on every load.
    req_data[2*IN_W +: IN_W] = wordf(8'hA0);
    step("sc_load0", 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b0, 2'd0, 1'b0, 1'b0);
    chkw("sc_w0", wordf(8'hA0));
    req_data[2*IN_W +: IN_W] = wordf(8'hA1);
    step("sc_load1", 4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd0, 1'b0, 1'b0);
    chkw("sc_w1", wordf(8'hA1));
    step("sc_xfer1", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b0, 1'b0);
    for (int k = 0; k < 2*NSEG; k++)
      step($sformatf("sc_beat%0d", k), 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2,
           (k % NSEG) == NSEG-1, 1'b0);

    // Reset in the middle of a ch1 word (rr_ptr is 3 beforehand, 2 after this grant).
    step("rm_load", 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b0);
    step("rm_xfer", 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++)
      step($sformatf("rm_beat%0d", k), 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chkw("rm.data_in", '0);
    step("rm_zero", 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 1'b0);
    step("rm_ptr0", 4'b1010, 1'b0, 1'b0, 4'b0010, 1'b0, 2'd0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
